contador_modulo_n: RTL and testbench
====================================

# contador_modulo_n

Parametrised modulo-N counter and successor to the fixed mod-11 up-counter, with the same registered-output D/Q structure. It adds the following:
- configurable width and modulus;
- up/down direction;
- count enable;
- synchronous load with clamping;
- a one-shot mode that stops at the terminal value;
- a terminal pulse and a saturating wrap counter.

It serves as the general timing and sequencing counter for the examples built on top of it.

## Interface
- `WIDTH`, 4: bit width of the count. Legal range is 1..16.
- `MODULO`, 11: number of count states, 0..MODULO-1. Legal range is 2..2^WIDTH; elaboration fails outside this range.
- `VALOR_INICIAL`, 0: count value after reset. Must be < MODULO.

- `i_clk`, input, 1: clock. All state changes on the rising edge.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_habilitar`, input, 1: count enable.
- `i_sentido`, input, 1: direction. 1 = up, 0 = down.
- `i_modo`, input, 1: mode. 0 = continuous (wrap), 1 = one-shot (stop at terminal).
- `i_cargar`, input, 1: synchronous load strobe.
- `i_valor`, input, WIDTH: load value.
- `o_cuenta`, output, WIDTH: current count. Registered.
- `o_tope`, output, 1: one-cycle terminal-event pulse. Registered.
- `o_detenido`, output, 1: high while the one-shot mode is stopped. Registered.
- `o_vueltas`, output, 8: number of continuous-mode wraps, saturating at 255. Registered.

## Operation
- **Terminal value** depends on the current `i_sentido`: MODULO-1 when counting up, 0 when counting down.
- **Terminal event:** a rising edge with `i_habilitar`=1, no load, state CONTANDO, and `o_cuenta` equal to the terminal value.
- **Priority per edge:** `i_rst` > `i_cargar` > `i_habilitar` > hold.
- **Reset:**
  - `o_cuenta`=VALOR_INICIAL;
  - `o_tope`=0, `o_detenido`=0, `o_vueltas`=0;
  - state = CONTANDO.
  - Reset applies equally mid-count or while DETENIDO.
- **Load:**
  - `o_cuenta` = `i_valor` if `i_valor` < MODULO; otherwise `o_cuenta` = MODULO-1 (clamped).
  - State goes to CONTANDO and `o_tope`=0.
  - `o_vueltas` is unchanged.
- **Enabled, non-terminal:** count changes by +1 (up) or -1 (down), computed from the registered count. `o_tope`=0.
- **Terminal event, continuous mode (`i_modo`=0):**
  - count wraps to 0 (up) or to MODULO-1 (down);
  - `o_tope`=1 for exactly one cycle;
  - `o_vueltas` += 1, saturating at 255.
- **Terminal event, one-shot mode (`i_modo`=1):**
  - count holds at the terminal value;
  - state goes to DETENIDO;
  - `o_tope`=1 for one cycle;
  - `o_vueltas` is unchanged.
- **State machine:**
  - CONTANDO → DETENIDO on a one-shot terminal event.
  - DETENIDO → CONTANDO only on load or reset.
  - In DETENIDO, `i_habilitar`, `i_sentido` and `i_modo` are ignored and the count holds.
- **Disabled (`i_habilitar`=0):** count and state hold; `o_tope`=0.
- **Arithmetic:**
  - next-count logic is WIDTH bits wide, with no intermediate overflow;
  - wrap is detected by comparison against the terminal value, never by natural rollover;
  - MODULO = 2^WIDTH must behave identically to any other legal MODULO.
- **Changing `i_sentido` or `i_modo` mid-count:** takes effect on the next enabled edge; no state is corrupted.
- **One-shot with the count already at the terminal value for the current direction:** the next enabled edge is immediately a terminal event.

## Timing
- Every output is a flop (Q) output; next-state logic is purely combinational from Q and the inputs.
- Latency from any input to the affected output is 1 cycle.
- `o_tope` is high in the same cycle that `o_cuenta` first shows the wrapped value (continuous mode) or the stopped value (one-shot mode).
- `o_detenido` rises in the same cycle as the one-shot `o_tope` pulse.
- No output changes between clock edges.
- Throughput: one count step per enabled cycle.

## Test plan
Defaults throughout: WIDTH=4, MODULO=11, VALOR_INICIAL=0.

1. **Continuous up-count:** reset, then 11 enabled up edges (`i_modo`=0) → `o_cuenta` 1..10 then 0; `o_tope`=1 only in the cycle showing 0; `o_vueltas`=1.
2. **Continuous down-count:** load 2, then enabled down edges → `o_cuenta` 1, 0, 10; `o_tope`=1 with 10; `o_vueltas`=1.
3. **Load clamping:** load 13 → `o_cuenta`=10. Load 15 with `i_habilitar`=1 on the same edge → `o_cuenta`=10 (load wins, no increment). Load 4 → `o_cuenta`=4.
4. **One-shot:**
   - load 8 with `i_modo`=1, then enabled up edges → 9, 10; the next edge keeps 10 with `o_tope` pulse and `o_detenido`=1;
   - 5 further enabled edges → 10 held, `o_tope`=0;
   - load 3 → `o_cuenta`=3, `o_detenido`=0.
5. **Reset mid-operation:** assert `i_rst` together with `i_cargar` and `i_habilitar` while DETENIDO → next cycle `o_cuenta`=0, `o_detenido`=0, `o_tope`=0, `o_vueltas`=0.
6. **Wrap-counter saturation:** 11×256 enabled up edges in continuous mode → `o_vueltas` reaches 255 and holds; `o_tope` still pulses on every wrap.

Source files
------------

// File: rtl/contador_modulo_n.sv
// rtl/contador_modulo_n.sv - parametrised modulo-N up/down counter with load, one-shot stop and wrap count
module contador_modulo_n #(
  parameter int WIDTH         = 4,
  parameter int MODULO        = 11,
  parameter int VALOR_INICIAL = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_habilitar,
  input  logic             i_sentido,
  input  logic             i_modo,
  input  logic             i_cargar,
  input  logic [WIDTH-1:0] i_valor,
  output logic [WIDTH-1:0] o_cuenta,
  output logic             o_tope,
  output logic             o_detenido,
  output logic [7:0]       o_vueltas
);

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("contador_modulo_n: WIDTH out of range 1..16");
    end
    if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
      $error("contador_modulo_n: MODULO out of range 2..2^WIDTH");
    end
    if (VALOR_INICIAL < 0 || VALOR_INICIAL >= MODULO) begin : g_bad_inicial
      $error("contador_modulo_n: VALOR_INICIAL must be below MODULO");
    end
  endgenerate

  // MOD_EXT carries one extra bit so MODULO = 2^WIDTH is representable
  localparam logic [WIDTH-1:0] MAXIMO  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] INICIAL = WIDTH'(VALOR_INICIAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  typedef enum logic {
    CONTANDO = 1'b0,
    DETENIDO = 1'b1
  } estado_t;

  estado_t          estado_q, estado_n;
  logic [WIDTH-1:0] cuenta_q, cuenta_n;
  logic             tope_q, tope_n;
  logic [7:0]       vueltas_q, vueltas_n;
  logic             en_terminal;
  logic             valor_valido;

  assign valor_valido = ({1'b0, i_valor} < MOD_EXT);
  assign en_terminal  = i_sentido ? (cuenta_q == MAXIMO) : (cuenta_q == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      estado_q  <= CONTANDO;
      cuenta_q  <= INICIAL;
      tope_q    <= 1'b0;
      vueltas_q <= 8'd0;
    end else begin
      estado_q  <= estado_n;
      cuenta_q  <= cuenta_n;
      tope_q    <= tope_n;
      vueltas_q <= vueltas_n;
    end
  end

  always_comb begin
    estado_n  = estado_q;
    cuenta_n  = cuenta_q;
    tope_n    = 1'b0;
    vueltas_n = vueltas_q;
    if (i_cargar) begin
      cuenta_n = valor_valido ? i_valor : MAXIMO;
      estado_n = CONTANDO;
    end else if (i_habilitar && estado_q == CONTANDO) begin
      if (en_terminal) begin
        tope_n = 1'b1;
        if (i_modo) begin
          estado_n = DETENIDO;
        end else begin
          // wrap by explicit reload, never by natural rollover
          cuenta_n  = i_sentido ? '0 : MAXIMO;
          vueltas_n = (vueltas_q != 8'hFF) ? vueltas_q + 8'd1 : vueltas_q;
        end
      end else begin
        cuenta_n = i_sentido ? cuenta_q + 1'b1 : cuenta_q - 1'b1;
      end
    end
  end

  assign o_cuenta   = cuenta_q;
  assign o_tope     = tope_q;
  assign o_detenido = (estado_q == DETENIDO);
  assign o_vueltas  = vueltas_q;

endmodule

// File: tb/tb_contador_modulo_n.sv
// tb/tb_contador_modulo_n.sv - self-checking bench for contador_modulo_n (mod-11 and full-range mod-8 instances)
module tb_contador_modulo_n;

  logic       i_clk;
  logic       i_rst, i_habilitar, i_sentido, i_modo, i_cargar;
  logic [3:0] i_valor;
  logic [3:0] o_cuenta;
  logic       o_tope, o_detenido;
  logic [7:0] o_vueltas;
  logic [2:0] b_cuenta;
  logic       b_tope, b_detenido;
  logic [7:0] b_vueltas;

  int errors = 0;
  int checks = 0;

  int m_cnt[2];
  int m_vue[2];
  bit m_tope[2];
  bit m_det[2];
  int mods[2] = '{11, 8};

  contador_modulo_n #(.WIDTH(4), .MODULO(11), .VALOR_INICIAL(0)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_habilitar(i_habilitar), .i_sentido(i_sentido),
    .i_modo(i_modo), .i_cargar(i_cargar), .i_valor(i_valor),
    .o_cuenta(o_cuenta), .o_tope(o_tope), .o_detenido(o_detenido), .o_vueltas(o_vueltas)
  );

  contador_modulo_n #(.WIDTH(3), .MODULO(8), .VALOR_INICIAL(0)) u_dut8 (
    .i_clk(i_clk), .i_rst(i_rst), .i_habilitar(i_habilitar), .i_sentido(i_sentido),
    .i_modo(i_modo), .i_cargar(i_cargar), .i_valor(i_valor[2:0]),
    .o_cuenta(b_cuenta), .o_tope(b_tope), .o_detenido(b_detenido), .o_vueltas(b_vueltas)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: counting is modular arithmetic; a wrap is seen when the result jumps to the far end.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int v, nxt;
      v = (k == 0) ? int'(i_valor) : int'(i_valor[2:0]);
      m_tope[k] = 0;
      if (i_rst) begin
        m_cnt[k] = 0; m_det[k] = 0; m_vue[k] = 0;
      end else if (i_cargar) begin
        m_cnt[k] = (v < mods[k]) ? v : mods[k] - 1;
        m_det[k] = 0;
      end else if (i_habilitar && !m_det[k]) begin
        nxt = i_sentido ? (m_cnt[k] + 1) % mods[k] : (m_cnt[k] + mods[k] - 1) % mods[k];
        if ((i_sentido && nxt == 0) || (!i_sentido && nxt == mods[k] - 1)) begin
          m_tope[k] = 1;
          if (i_modo) m_det[k] = 1;
          else begin
            m_cnt[k] = nxt;
            if (m_vue[k] < 255) m_vue[k]++;
          end
        end else begin
          m_cnt[k] = nxt;
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(bit rst, bit hab, bit sen, bit modo, bit carg, int val);
    i_rst = rst; i_habilitar = hab; i_sentido = sen; i_modo = modo; i_cargar = carg;
    i_valor = 4'(val);
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 0, 0, 0);
    tick();
    checks++;
    if (o_cuenta !== 4'd0 || o_tope !== 1'b0 || o_detenido !== 1'b0 || o_vueltas !== 8'd0) begin
      errors++;
      $display("FAIL reset: cuenta=%0d tope=%0b det=%0b vueltas=%0d, expected 0 0 0 0",
               o_cuenta, o_tope, o_detenido, o_vueltas);
    end
    drive(0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_continuous_up();
    int exp_c;
    test_reset();
    for (int k = 1; k <= 11; k++) begin
      drive(0, 1, 1, 0, 0, 0);
      tick();
      exp_c = (k == 11) ? 0 : k;
      checks++;
      if (o_cuenta !== 4'(exp_c) || o_tope !== (k == 11)) begin
        errors++;
        $display("FAIL cont_up step %0d: cuenta=%0d tope=%0b, expected %0d %0b",
                 k, o_cuenta, o_tope, exp_c, (k == 11));
      end
    end
    checks++;
    if (o_vueltas !== 8'd1) begin
      errors++;
      $display("FAIL cont_up vueltas: got %0d expected 1", o_vueltas);
    end
  endtask

  task automatic test_continuous_down();
    int exp_seq[3] = '{1, 0, 10};
    test_reset();
    drive(0, 0, 1, 0, 1, 2);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0, 0);
      tick();
      checks++;
      if (o_cuenta !== 4'(exp_seq[k]) || o_tope !== (k == 2)) begin
        errors++;
        $display("FAIL cont_down step %0d: cuenta=%0d tope=%0b, expected %0d %0b",
                 k, o_cuenta, o_tope, exp_seq[k], (k == 2));
      end
    end
    checks++;
    if (o_vueltas !== 8'd1) begin
      errors++;
      $display("FAIL cont_down vueltas: got %0d expected 1", o_vueltas);
    end
  endtask

  task automatic test_load_clamp();
    int vals[3] = '{13, 15, 4};
    int habs[3] = '{0, 1, 0};
    int exps[3] = '{10, 10, 4};
    test_reset();
    for (int k = 0; k < 3; k++) begin
      drive(0, habs[k][0], 1, 0, 1, vals[k]);
      tick();
      checks++;
      if (o_cuenta !== 4'(exps[k]) || o_tope !== 1'b0) begin
        errors++;
        $display("FAIL load %0d: cuenta=%0d tope=%0b, expected %0d 0", vals[k], o_cuenta, o_tope, exps[k]);
      end
    end
  endtask

  task automatic test_one_shot();
    test_reset();
    drive(0, 0, 1, 1, 1, 8);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 1, 0, 0);
      tick();
      checks++;
      if (o_cuenta !== 4'((k == 0) ? 9 : 10) || o_tope !== (k == 2) || o_detenido !== (k == 2)) begin
        errors++;
        $display("FAIL one_shot step %0d: cuenta=%0d tope=%0b det=%0b", k, o_cuenta, o_tope, o_detenido);
      end
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, k[0], k[1], 0, 0);
      tick();
      checks++;
      if (o_cuenta !== 4'd10 || o_tope !== 1'b0 || o_detenido !== 1'b1) begin
        errors++;
        $display("FAIL one_shot hold %0d: cuenta=%0d tope=%0b det=%0b, expected 10 0 1",
                 k, o_cuenta, o_tope, o_detenido);
      end
    end
    checks++;
    if (o_vueltas !== 8'd0) begin
      errors++;
      $display("FAIL one_shot vueltas: got %0d expected 0", o_vueltas);
    end
    drive(0, 0, 1, 1, 1, 3);
    tick();
    checks++;
    if (o_cuenta !== 4'd3 || o_detenido !== 1'b0) begin
      errors++;
      $display("FAIL one_shot reload: cuenta=%0d det=%0b, expected 3 0", o_cuenta, o_detenido);
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    drive(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) tick();
    drive(0, 1, 0, 1, 0, 0);
    for (int k = 0; k < 11; k++) tick();
    checks++;
    if (o_detenido !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid setup: det=%0b expected 1", o_detenido);
    end
    drive(1, 1, 1, 0, 1, 7);
    tick();
    checks++;
    if (o_cuenta !== 4'd0 || o_detenido !== 1'b0 || o_tope !== 1'b0 || o_vueltas !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: cuenta=%0d det=%0b tope=%0b vueltas=%0d, expected 0 0 0 0",
               o_cuenta, o_detenido, o_tope, o_vueltas);
    end
    drive(0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_saturation();
    int pulses = 0;
    test_reset();
    drive(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 11 * 256; k++) begin
      tick();
      if (o_tope) pulses++;
      if (k == 11 * 255 - 1) begin
        checks++;
        if (o_vueltas !== 8'd255) begin
          errors++;
          $display("FAIL sat reach: vueltas=%0d expected 255", o_vueltas);
        end
      end
    end
    checks++;
    if (o_vueltas !== 8'd255 || pulses != 256) begin
      errors++;
      $display("FAIL sat hold: vueltas=%0d pulses=%0d, expected 255 256", o_vueltas, pulses);
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_det[k] = 0; m_vue[k] = 0; m_tope[k] = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75, 1'($urandom),
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8, int'($urandom_range(0, 15)));
      tick();
      checks++;
      if (o_cuenta !== 4'(m_cnt[0]) || o_tope !== m_tope[0] || o_detenido !== m_det[0] ||
          o_vueltas !== 8'(m_vue[0])) begin
        errors++;
        $display("FAIL random mod11 cyc %0d: got %0d/%0b/%0b/%0d expected %0d/%0b/%0b/%0d", n,
                 o_cuenta, o_tope, o_detenido, o_vueltas, m_cnt[0], m_tope[0], m_det[0], m_vue[0]);
      end
      checks++;
      if (b_cuenta !== 3'(m_cnt[1]) || b_tope !== m_tope[1] || b_detenido !== m_det[1] ||
          b_vueltas !== 8'(m_vue[1])) begin
        errors++;
        $display("FAIL random mod8 cyc %0d: got %0d/%0b/%0b/%0d expected %0d/%0b/%0b/%0d", n,
                 b_cuenta, b_tope, b_detenido, b_vueltas, m_cnt[1], m_tope[1], m_det[1], m_vue[1]);
      end
    end
  endtask

  initial begin
    drive(1, 0, 1, 0, 0, 0);
    test_reset();
    test_continuous_up();
    test_continuous_down();
    test_load_clamp();
    test_one_shot();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
